dino_scene_renderer: RTL and testbench

- Reads the game-state outputs of the game logic block (dino_y, obstacle_x, game_over, dino_state) and turns them into per-pixel colour for the VGA output stage.
- Latches the game state once per frame, during blanking, so a frame never shows a mix of two game states.
- Looks up the dino and obstacle 1bpp bitmaps in two external sprite ROMs.
- Outputs a 12-bit RGB stream aligned to the incoming pixel coordinates, delayed by a fixed 2-cycle latency.

---
 rtl/dino_scene_renderer_if.sv | 38 +++
 rtl/dino_scene_renderer.sv | 177 +++++++++++++++++
 tb/tb_dino_scene_renderer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dino_scene_renderer_if.sv
// Signal bundle between the game/VGA environment and the scene renderer.
// The master side presents pixel coordinates, game state and ROM read data.
// The slave side (the renderer) returns ROM addresses and the colour stream.
interface dino_scene_renderer_if;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        pixel_valid;
    logic        frame_start;

    logic [11:0] dino_y;
    logic [11:0] obstacle_x;
    logic        game_over;
    logic [1:0]  dino_state;

    logic [11:0] dino_rom_addr;
    logic        dino_rom_data;
    logic [9:0]  obs_rom_addr;
    logic        obs_rom_data;

    logic [11:0] rgb;
    logic        rgb_valid;

    modport master (
        output pixel_x, pixel_y, pixel_valid, frame_start,
        output dino_y, obstacle_x, game_over, dino_state,
        output dino_rom_data, obs_rom_data,
        input  dino_rom_addr, obs_rom_addr,
        input  rgb, rgb_valid
    );

    modport slave (
        input  pixel_x, pixel_y, pixel_valid, frame_start,
        input  dino_y, obstacle_x, game_over, dino_state,
        input  dino_rom_data, obs_rom_data,
        output dino_rom_addr, obs_rom_addr,
        output rgb, rgb_valid
    );
endinterface

// File: rtl/dino_scene_renderer.sv
// Scene renderer: turns the per-frame game state into a 12-bit RGB pixel
// stream. Game state is snapshotted on frame_start (vertical blank) so one
// frame never mixes two states. Pipeline:
//   stage 0 : hit tests and sprite ROM addresses from the incoming pixel
//   stage 1 : hit flags travel alongside the ROM read
//   stage 2 : colour priority (dino > obstacle > ground > background)
// Output is exactly two cycles behind the pixel, one pixel per cycle.
module dino_scene_renderer #(
    parameter logic [11:0] V_RES             = 12'd480,
    parameter logic [11:0] DINO_SCREEN_X     = 12'd40,
    parameter logic [11:0] GROUND_SCREEN_Y   = 12'd300,
    parameter logic [11:0] OBSTACLE_INIT_X   = 12'd200,
    parameter logic [11:0] OBSTACLE_CENTER_X = 12'd16,
    parameter int          SPR_W             = 32,
    parameter int          SPR_H             = 32,
    parameter logic [11:0] COL_BG            = 12'hFFF,
    parameter logic [11:0] COL_GROUND        = 12'h555,
    parameter logic [11:0] COL_SPRITE        = 12'h333,
    parameter logic [11:0] COL_DEAD          = 12'hF00
) (
    input  logic                        vga_clk,
    input  logic                        rst_n,
    dino_scene_renderer_if.slave        bus
);

    // Geometry constants in the 13-bit signed domain used by all hit tests,
    // so an obstacle hanging off the left edge (negative ox) compares correctly.
    localparam logic signed [12:0] V_RES_S    = $signed({1'b0, V_RES});
    localparam logic signed [12:0] DINO_X_S   = $signed({1'b0, DINO_SCREEN_X});
    localparam logic signed [12:0] GROUND_S   = $signed({1'b0, GROUND_SCREEN_Y});
    localparam logic signed [12:0] OBS_CTR_S  = $signed({1'b0, OBSTACLE_CENTER_X});
    localparam logic signed [12:0] SPR_W_S    = 13'(SPR_W);
    localparam logic signed [12:0] SPR_H_S    = 13'(SPR_H);
    localparam logic signed [12:0] ONE_S      = 13'sd1;

    // Per-frame snapshot of the game state
    logic [11:0] sh_dino_y;
    logic [11:0] sh_obstacle_x;
    logic        sh_game_over;
    logic [1:0]  sh_dino_state;

    // Stage 0 combinational results
    logic signed [12:0] px;
    logic signed [12:0] py;
    logic signed [12:0] gy;
    logic signed [12:0] dy;
    logic signed [12:0] ox;
    logic signed [12:0] dino_dy;
    logic signed [12:0] obs_dy;
    logic               dino_hit;
    logic               obs_hit;
    logic               ground_hit;
    logic [4:0]         dino_row;
    logic [4:0]         dino_col;
    logic [4:0]         obs_row;
    logic [4:0]         obs_col;

    // Stage 1 registers (aligned with the ROM read)
    logic [11:0] dino_addr_q;
    logic [9:0]  obs_addr_q;
    logic        dino_hit_s1;
    logic        obs_hit_s1;
    logic        ground_s1;
    logic        valid_s1;
    logic        dead_s1;

    // Stage 2 output registers
    logic [11:0] pix_colour;
    logic [11:0] sprite_colour;
    logic [11:0] rgb_q;
    logic        rgb_valid_q;

    // Snapshot game state once per frame; a pixel in the same cycle still sees the old values
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_dino_y     <= GROUND_SCREEN_Y;
            sh_obstacle_x <= OBSTACLE_INIT_X;
            sh_game_over  <= 1'b0;
            sh_dino_state <= 2'd0;
        end else if (bus.frame_start) begin
            sh_dino_y     <= bus.dino_y;
            sh_obstacle_x <= bus.obstacle_x;
            sh_game_over  <= bus.game_over;
            sh_dino_state <= bus.dino_state;
        end
    end

    // Stage 0: convert to game coordinates, run hit tests, form ROM addresses
    always_comb begin
        px       = $signed({1'b0, bus.pixel_x});
        py       = $signed({1'b0, bus.pixel_y});
        gy       = V_RES_S - ONE_S - py;
        dy       = $signed({1'b0, sh_dino_y});
        ox       = $signed({1'b0, sh_obstacle_x}) - OBS_CTR_S;

        dino_dy  = gy - dy;
        obs_dy   = gy - GROUND_S;

        dino_hit = (px >= DINO_X_S) && (px < DINO_X_S + SPR_W_S) &&
                   (gy >= dy)       && (gy < dy + SPR_H_S);
        obs_hit  = (px >= ox)       && (px < ox + SPR_W_S) &&
                   (gy >= GROUND_S) && (gy < GROUND_S + SPR_H_S);
        ground_hit = (gy == GROUND_S - ONE_S);

        // ROM rows are stored top-first while game y grows upwards
        dino_col = 5'(px - DINO_X_S);
        dino_row = 5'(SPR_H_S - ONE_S - dino_dy);
        obs_col  = 5'(px - ox);
        obs_row  = 5'(SPR_H_S - ONE_S - obs_dy);
    end

    // ROM addresses only move on a hit so the ROMs stay quiet elsewhere
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            dino_addr_q <= 12'd0;
            obs_addr_q  <= 10'd0;
        end else begin
            if (dino_hit) begin
                dino_addr_q <= {sh_dino_state, dino_row, dino_col};
            end
            if (obs_hit) begin
                obs_addr_q <= {obs_row, obs_col};
            end
        end
    end

    // Stage 1: carry hit flags, validity and the frame's game_over next to the ROM read
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            dino_hit_s1 <= 1'b0;
            obs_hit_s1  <= 1'b0;
            ground_s1   <= 1'b0;
            valid_s1    <= 1'b0;
            dead_s1     <= 1'b0;
        end else begin
            dino_hit_s1 <= dino_hit;
            obs_hit_s1  <= obs_hit;
            ground_s1   <= ground_hit;
            valid_s1    <= bus.pixel_valid;
            dead_s1     <= sh_game_over;
        end
    end

    // Stage 2 colour priority; a transparent dino bit falls through to the obstacle
    always_comb begin
        sprite_colour = dead_s1 ? COL_DEAD : COL_SPRITE;
        pix_colour    = 12'd0;
        if (valid_s1) begin
            if (dino_hit_s1 && bus.dino_rom_data) begin
                pix_colour = sprite_colour;
            end else if (obs_hit_s1 && bus.obs_rom_data) begin
                pix_colour = sprite_colour;
            end else if (ground_s1) begin
                pix_colour = COL_GROUND;
            end else begin
                pix_colour = COL_BG;
            end
        end
    end

    // Stage 2 output register
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= 12'd0;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_q       <= pix_colour;
            rgb_valid_q <= valid_s1;
        end
    end

    assign bus.dino_rom_addr = dino_addr_q;
    assign bus.obs_rom_addr  = obs_addr_q;
    assign bus.rgb           = rgb_q;
    assign bus.rgb_valid     = rgb_valid_q;

endmodule

// File: tb/tb_dino_scene_renderer.sv
// Directed bench for dino_scene_renderer: hand-computed addresses and colours.
module tb_dino_scene_renderer;

    logic vga_clk;
    logic rst_n;

    dino_scene_renderer_if bus ();

    dino_scene_renderer dut (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_checks;
    int n_fail;

    logic [11:0] d_addr_seen;
    logic [9:0]  o_addr_seen;
    logic        early_valid_seen;
    logic [11:0] rgb_seen;
    logic        vld_seen;

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Latch a new game state with a one-cycle frame_start pulse
    task automatic latch(input logic [11:0] dy, input logic [11:0] ox,
                         input logic go, input logic [1:0] st);
        @(negedge vga_clk);
        bus.dino_y      = dy;
        bus.obstacle_x  = ox;
        bus.game_over   = go;
        bus.dino_state  = st;
        bus.frame_start = 1'b1;
        @(negedge vga_clk);
        bus.frame_start = 1'b0;
    endtask

    // Present one pixel, answer its ROM reads one cycle later, capture the output
    task automatic pix(input logic [11:0] x, input logic [11:0] y,
                       input logic v, input logic db, input logic ob);
        @(negedge vga_clk);
        bus.pixel_x     = x;
        bus.pixel_y     = y;
        bus.pixel_valid = v;
        @(negedge vga_clk);
        bus.pixel_valid   = 1'b0;
        d_addr_seen       = bus.dino_rom_addr;
        o_addr_seen       = bus.obs_rom_addr;
        early_valid_seen  = bus.rgb_valid;
        bus.dino_rom_data = db;
        bus.obs_rom_data  = ob;
        @(negedge vga_clk);
        rgb_seen = bus.rgb;
        vld_seen = bus.rgb_valid;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n            = 1'b1;
        bus.pixel_x      = 12'd0;
        bus.pixel_y      = 12'd0;
        bus.pixel_valid  = 1'b0;
        bus.frame_start  = 1'b0;
        bus.dino_y       = 12'd300;
        bus.obstacle_x   = 12'd200;
        bus.game_over    = 1'b0;
        bus.dino_state   = 2'd0;
        bus.dino_rom_data = 1'b0;
        bus.obs_rom_data  = 1'b0;

        #2 rst_n = 1'b0;
        @(negedge vga_clk);
        check_eq("reset_rgb",       32'(bus.rgb), 32'h0);
        check_eq("reset_rgb_valid", 32'(bus.rgb_valid), 32'h0);
        check_eq("reset_dino_addr", 32'(bus.dino_rom_addr), 32'h0);
        check_eq("reset_obs_addr",  32'(bus.obs_rom_addr), 32'h0);
        @(negedge vga_clk);
        rst_n = 1'b1;

        // Default state, dino feet pixel
        latch(12'd300, 12'd200, 1'b0, 2'd0);
        pix(12'd40, 12'd179, 1'b1, 1'b1, 1'b0);
        check_eq("dino_addr_default", 32'(d_addr_seen), 32'd992);
        check_eq("valid_after_1",     32'(early_valid_seen), 32'd0);
        check_eq("rgb_dino_run",      32'(rgb_seen), 32'h333);
        check_eq("rgb_valid_dino",    32'(vld_seen), 32'd1);

        // Jump frame
        latch(12'd300, 12'd200, 1'b0, 2'd2);
        pix(12'd40, 12'd179, 1'b1, 1'b1, 1'b0);
        check_eq("dino_addr_jump", 32'(d_addr_seen), 32'd3040);

        // Mid-frame change of dino_y must not take effect
        bus.dino_y = 12'd100;
        pix(12'd40, 12'd179, 1'b1, 1'b1, 1'b0);
        check_eq("dino_addr_midframe", 32'(d_addr_seen), 32'd3040);
        check_eq("rgb_midframe",       32'(rgb_seen), 32'h333);

        // New frame picks up dino_y=100
        latch(12'd100, 12'd200, 1'b0, 2'd2);
        pix(12'd40, 12'd369, 1'b1, 1'b1, 1'b0);
        check_eq("dino_addr_dy100", 32'(d_addr_seen), 32'd2720);
        check_eq("rgb_dy100",       32'(rgb_seen), 32'h333);
        pix(12'd40, 12'd179, 1'b1, 1'b1, 1'b1);
        check_eq("rgb_old_dino_pos", 32'(rgb_seen), 32'hFFF);

        // Obstacle clipped at the left edge
        latch(12'd300, 12'd5, 1'b0, 2'd0);
        pix(12'd0, 12'd179, 1'b1, 1'b0, 1'b1);
        check_eq("obs_addr_clip", 32'(o_addr_seen), 32'd1003);
        check_eq("rgb_obs_clip",  32'(rgb_seen), 32'h333);
        pix(12'd21, 12'd179, 1'b1, 1'b0, 1'b1);
        check_eq("rgb_obs_right_edge", 32'(rgb_seen), 32'hFFF);
        check_eq("obs_addr_hold",      32'(o_addr_seen), 32'd1003);

        // Overlap: transparent dino bit falls through to obstacle
        latch(12'd300, 12'd56, 1'b0, 2'd0);
        pix(12'd40, 12'd179, 1'b1, 1'b0, 1'b1);
        check_eq("overlap_dino_addr", 32'(d_addr_seen), 32'd992);
        check_eq("overlap_obs_addr",  32'(o_addr_seen), 32'd992);
        check_eq("rgb_overlap_run",   32'(rgb_seen), 32'h333);

        latch(12'd300, 12'd56, 1'b1, 2'd3);
        pix(12'd40, 12'd179, 1'b1, 1'b0, 1'b1);
        check_eq("rgb_overlap_dead", 32'(rgb_seen), 32'hF00);
        pix(12'd40, 12'd179, 1'b1, 1'b1, 1'b0);
        check_eq("rgb_dino_dead", 32'(rgb_seen), 32'hF00);
        pix(12'd40, 12'd179, 1'b1, 1'b0, 1'b0);
        check_eq("rgb_both_clear", 32'(rgb_seen), 32'hFFF);

        // Ground line and blanking
        pix(12'd100, 12'd180, 1'b1, 1'b1, 1'b1);
        check_eq("rgb_ground", 32'(rgb_seen), 32'h555);
        pix(12'd40, 12'd179, 1'b0, 1'b1, 1'b1);
        check_eq("rgb_blank",       32'(rgb_seen), 32'h0);
        check_eq("rgb_valid_blank", 32'(vld_seen), 32'd0);

        // Mid-line reset with a valid pixel in flight
        @(negedge vga_clk);
        bus.pixel_x     = 12'd40;
        bus.pixel_y     = 12'd179;
        bus.pixel_valid = 1'b1;
        bus.dino_rom_data = 1'b1;
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("pre_reset_valid", 32'(bus.rgb_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midreset_rgb",       32'(bus.rgb), 32'h0);
        check_eq("midreset_rgb_valid", 32'(bus.rgb_valid), 32'd0);
        check_eq("midreset_dino_addr", 32'(bus.dino_rom_addr), 32'h0);
        check_eq("midreset_obs_addr",  32'(bus.obs_rom_addr), 32'h0);
        bus.pixel_valid = 1'b0;
        @(negedge vga_clk);
        rst_n = 1'b1;

        // Shadow state back to defaults: dino_y=300, not dead, state 0
        pix(12'd40, 12'd179, 1'b1, 1'b1, 1'b0);
        check_eq("post_reset_valid_1", 32'(early_valid_seen), 32'd0);
        check_eq("post_reset_valid_2", 32'(vld_seen), 32'd1);
        check_eq("post_reset_dino_addr", 32'(d_addr_seen), 32'd992);
        check_eq("post_reset_rgb",       32'(rgb_seen), 32'h333);
        // obstacle_x=200 -> ox=184
        pix(12'd184, 12'd179, 1'b1, 1'b0, 1'b1);
        check_eq("post_reset_obs_addr", 32'(o_addr_seen), 32'd992);
        check_eq("post_reset_obs_rgb",  32'(rgb_seen), 32'h333);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
